sample8_uart_tx: RTL and testbench

SAMPLE8_UART_TX -- requirements
Module: sample8_uart_tx

---
 rtl/sample8_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_sample8_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample8_uart_tx.sv
// sample8_uart_tx: buffers 8-bit boolean samples in a small FIFO and sends
// each one as an 8N1 frame (start, 8 data bits LSB first, stop).
// The tx and busy outputs come from flops driven by the FSM's current state.
// As a result, the line trails the state register by one clock. The frame
// length is still exactly 10 bit periods, and frames follow each other with
// no gap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high; pops the FIFO head as soon as one is available
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | shift-register bit[bit_idx] on the line, bit_idx 0..7
// STOP  | stop bit (high); at its end, pop the next sample or go idle

module sample8_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [BAUD_W-1:0] baud_cnt, baud_nx;
  logic [2:0]        bit_idx, bit_nx;
  logic [7:0]        shreg, shreg_nx;
  logic              tx_nx;
  logic              baud_end;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;
  logic              fifo_empty;

  assign sample_ready = (fifo_count != DEPTH_C);
  assign fifo_empty   = (fifo_count == '0);
  assign push         = sample_valid & sample_ready;
  assign baud_end     = (baud_cnt == BAUD_LAST);

  // Sample storage. It needs no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow: a sample offered while the FIFO is full is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (sample_valid && !sample_ready) begin
      overflow <= 1'b1;
    end
  end

  // TX FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shreg    <= shreg_nx;
    end
  end

  // Next-state logic. A pop in IDLE or at the end of STOP loads the shift register directly.
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        bit_nx  = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = mem[rd_ptr];
          state_nx = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            bit_nx   = '0;
            state_nx = STOP;
          end else begin
            bit_nx = bit_idx + 1'b1;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nx = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            shreg_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level implied by the current state.
  always_comb begin
    tx_nx = 1'b1;
    case (state)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg[bit_idx];
      default: tx_nx = 1'b1;
    endcase
  end

  // Registered line and busy. They are driven from the same flop stage so both stay aligned with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= tx_nx;
      busy <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_sample8_uart_tx.sv
// Bench for sample8_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// The reference model tracks a queue of samples and the position within the current frame.
module tb_sample8_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sample8_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The line level is a function of the frame position:
  // slot 0 is the start bit, slots 1..8 are the data bits, and slot 9 is the stop bit.
  logic [7:0] q[$];
  int         eng_left = 0;
  logic [7:0] cur = 8'h00;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    int pos, slot, old_n;
    if (rst) begin
      q.delete();
      eng_left = 0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (eng_left == 0) begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end else begin
        pos    = FRAME - eng_left;
        slot   = pos / CPB;
        m_busy = 1'b1;
        if (slot == 0)      m_tx = 1'b0;
        else if (slot == 9) m_tx = 1'b1;
        else                m_tx = cur[slot-1];
      end
      old_n = q.size();
      if (eng_left > 0) eng_left--;
      if (eng_left == 0 && old_n > 0) begin
        cur      = q.pop_front();
        eng_left = FRAME;
      end
      if (sample_valid) begin
        if (old_n < DEPTH) q.push_back(sample_in);
        else               m_ovf = 1'b1;
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    check("tx", tx, m_tx);
    check("busy", busy, m_busy);
    check("fifo_count", fifo_count, q.size());
    check("sample_ready", sample_ready, (q.size() != DEPTH));
    check("overflow", overflow, m_ovf);
  end

  task automatic push(input logic [7:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || fifo_count != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("idle_timeout", (n < 1000), 1);
  endtask

  bit exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int peak, run, maxrun, bad_line;

    // Async reset values, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single 0xA5 frame. The line falls two edges after the push and lasts 40 cycles.
    push(8'hA5);
    @(negedge clk);
    check("a5_tx_after_push", tx, 1);
    @(negedge clk);
    check("a5_tx_pop_edge", tx, 1);
    check("a5_busy_pop_edge", busy, 0);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check("a5_line", tx, exp_a5[k/CPB]);
      check("a5_busy", busy, 1);
    end
    @(negedge clk);
    check("a5_busy_end", busy, 0);
    check("a5_tx_end", tx, 1);
    @(posedge clk);
    #1;

    // Three samples on consecutive cycles should produce back-to-back frames.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    peak = 0; run = 0; maxrun = 0;
    repeat (130) begin
      @(negedge clk);
      if (fifo_count > peak) peak = fifo_count;
      if (busy) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check("b2b_peak_count", peak, 2);
    check("b2b_busy_run", maxrun, 3 * FRAME);
    @(posedge clk);
    #1;

    // A push lands on the frame-end pop edge while two samples are queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (38) @(posedge clk);
    #1;
    check("pp_count_before", fifo_count, 2);
    push(8'h44);
    @(negedge clk);
    check("pp_count_after", fifo_count, 2);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // Hold valid for six cycles: five samples are accepted, and the sixth overflows.
    for (int i = 0; i < 6; i++) begin
      sample_in    = 8'h50 + 8'(i);
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 4) begin
        check("full_ready", sample_ready, 0);
        check("full_count", fifo_count, 4);
      end
    end
    sample_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", fifo_count, 4);
    repeat (10) @(posedge clk);
    #1;
    check("ovf_sticky", overflow, 1);

    // Reset during data bit 3 of 0x50 (a 0 on the line).
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_tx_bit3", tx, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bad_line = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad_line++;
    end
    check("no_partial_frame", bad_line, 0);
    @(posedge clk);
    #1;

    // First push after reset release is accepted at once.
    push(8'hC3);
    @(negedge clk);
    check("post_rst_count", fifo_count, 1);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
